// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 datapath stages (S-array init and key scheduling).
package arc4_pkg;

  // Size of the S permutation array; all index arithmetic wraps at this value.
  localparam int S_SIZE = 256;

  // Each key-scheduling step visits six states: read i, wait, read j, wait, write i, write j.
  localparam int KSA_CYCLES_PER_I = 6;

  typedef enum logic [2:0] {
    IDLE,
    RD_I,
    WT_I,
    RD_J,
    WT_J,
    WR_I,
    WR_J
  } ksa_state_t;

endpackage

// File: rtl/ksa.sv
// ARC4 key-scheduling stage: permutes the identity-filled S memory in place
// using the latched key, one swap per index over six clock cycles.
module ksa
  import arc4_pkg::*;
#(
  parameter int KEYLEN = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic                rdy,
  input  logic [8*KEYLEN-1:0] key,
  output logic [7:0]          addr,
  input  logic [7:0]          rddata,
  output logic [7:0]          wrdata,
  output logic                wren
);

  localparam int KIW = (KEYLEN > 1) ? $clog2(KEYLEN) : 1;
  localparam logic [7:0] LAST_I = 8'(S_SIZE - 1);
  localparam logic [KIW-1:0] LAST_K = KIW'(KEYLEN - 1);

  ksa_state_t          state_q;
  logic [7:0]          i_q;
  logic [7:0]          j_q;
  logic [7:0]          si_q;
  logic [7:0]          sj_q;
  logic [7:0]          addr_q;
  logic                wren_q;
  logic                rdy_q;
  logic [KIW-1:0]      keyIdx_q;
  logic [8*KEYLEN-1:0] key_q;
  logic [7:0]          j_d;

  // Key byte selected by the rolling i-mod-KEYLEN counter; byte 0 is the MSB of the key.
  function automatic logic [7:0] keyByte(input logic [8*KEYLEN-1:0] k,
                                         input logic [KIW-1:0] idx);
    logic [7:0] b;
    b = '0;
    for (int n = 0; n < KEYLEN; n++) begin
      if (idx == KIW'(n)) begin
        b = k[8*(KEYLEN-1-n) +: 8];
      end
    end
    return b;
  endfunction

  // Next j, formed while S[i] is arriving on rddata during WT_I; wraps mod 256.
  always_comb begin
    j_d = j_q + rddata + keyByte(key_q, keyIdx_q);
  end

  // Sequencer: each state prepares the registered memory controls for the state it enters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b1;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      i_q      <= '0;
      j_q      <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      keyIdx_q <= '0;
      key_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            key_q    <= key;
            i_q      <= '0;
            j_q      <= '0;
            keyIdx_q <= '0;
            rdy_q    <= 1'b0;
            wren_q   <= 1'b0;
            addr_q   <= '0;
            state_q  <= RD_I;
          end
        end
        RD_I: begin
          state_q <= WT_I;
        end
        WT_I: begin
          si_q    <= rddata;
          j_q     <= j_d;
          addr_q  <= j_d;
          state_q <= RD_J;
        end
        RD_J: begin
          state_q <= WT_J;
        end
        WT_J: begin
          sj_q    <= rddata;
          addr_q  <= i_q;
          wren_q  <= 1'b1;
          state_q <= WR_I;
        end
        WR_I: begin
          addr_q  <= j_q;
          state_q <= WR_J;
        end
        WR_J: begin
          wren_q <= 1'b0;
          if (i_q == LAST_I) begin
            rdy_q   <= 1'b1;
            addr_q  <= '0;
            state_q <= IDLE;
          end else begin
            i_q      <= i_q + 8'd1;
            keyIdx_q <= (keyIdx_q == LAST_K) ? '0 : keyIdx_q + 1'b1;
            addr_q   <= i_q + 8'd1;
            state_q  <= RD_I;
          end
        end
        default: begin
          rdy_q   <= 1'b1;
          wren_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Write data is S[j] into slot i, then S[i] into slot j; both halves come straight from
  // the latched bytes so no separate data register is needed.
  always_comb begin
    wrdata = (state_q == WR_J) ? si_q : sj_q;
  end

  assign addr = addr_q;
  assign wren = wren_q;
  assign rdy  = rdy_q;

endmodule
